// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the memory bus arbiter.
//   arb_state_t : arbitration state machine encoding
//   bus_owner_t : selects which requester drives the memory port
package arbiter_pkg;

  typedef enum logic [2:0] {
    CPU_OWN,
    HANDOVER,
    DMA_OWN,
    COOLDOWN,
    ArbStateEndMarker
  } arb_state_t;

  typedef enum logic {
    BusOwnerCpu,
    BusOwnerDma
  } bus_owner_t;

endpackage

// File: rtl/mem_bus_arbiter_reg.sv
// Loadable register with synchronous active-high reset to zero.
// Ports:
//   clk_in  : clock
//   reset   : synchronous, active-high
//   load_i  : capture d_i on the rising edge
//   d_i     : data in
//   q_o     : registered data out (holds when load_i=0)
module mem_bus_arbiter_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk_in,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one external memory port between the CPU (default owner) and a
// DMA requester. DMA is only granted while the CPU is reading, the CPU is
// stalled through cpu_ready, and each capped DMA burst is followed by a
// guaranteed CPU cycle.
// Ports:
//   clk_in, reset                      : clock, synchronous active-high reset
//   cpu_address/data_out/read_write    : CPU bus request (1=read)
//   cpu_data_in, cpu_ready             : read data and clock enable to CPU
//   dma_req/address/wdata/read_write   : DMA access request (1=read)
//   dma_gnt, dma_ack                   : DMA owns bus / access performed
//   dma_rdata, dma_rvalid              : registered DMA read data + valid
//   mem_address/wdata/read_write       : memory port outputs (1=read)
//   mem_rdata                          : combinational memory read data
module mem_bus_arbiter
  import arbiter_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 8
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_data_out,
  input  logic              cpu_read_write,
  output logic [DATA_W-1:0] cpu_data_in,
  output logic              cpu_ready,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_address,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic              dma_read_write,
  output logic              dma_gnt,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_rvalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [CNT_W-1:0] burst_inc;
  logic             dma_rvalid_q, dma_rvalid_d;
  bus_owner_t       owner;
  logic             rdata_load;

  assign cpu_data_in = mem_rdata;
  assign burst_inc   = burst_cnt_q + 1'b1;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q      <= CPU_OWN;
      burst_cnt_q  <= '0;
      dma_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      burst_cnt_q  <= burst_cnt_d;
      dma_rvalid_q <= dma_rvalid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    owner       = BusOwnerCpu;
    cpu_ready   = 1'b1;
    dma_gnt     = 1'b0;
    dma_ack     = 1'b0;
    unique case (state_q)
      CPU_OWN: begin
        // Only a CPU read may be interrupted; writes always complete.
        if (dma_req && cpu_read_write) begin
          state_d = HANDOVER;
        end
      end
      HANDOVER: begin
        cpu_ready   = 1'b0;
        state_d     = DMA_OWN;
        burst_cnt_d = '0;
      end
      DMA_OWN: begin
        owner     = BusOwnerDma;
        cpu_ready = 1'b0;
        dma_gnt   = 1'b1;
        dma_ack   = dma_req;
        if (!dma_req) begin
          state_d = CPU_OWN;
        end else begin
          burst_cnt_d = burst_inc;
          if (burst_inc == BURST_LAST) begin
            state_d = COOLDOWN;
          end
        end
      end
      COOLDOWN: begin
        state_d = CPU_OWN;
      end
      default: begin
        state_d = CPU_OWN;
      end
    endcase
  end

  // Memory port mux. HANDOVER is a read-only turnaround at the CPU address.
  always_comb begin
    mem_address    = cpu_address;
    mem_wdata      = cpu_data_out;
    mem_read_write = cpu_read_write;
    if (owner == BusOwnerDma) begin
      mem_address    = dma_address;
      mem_wdata      = dma_wdata;
      mem_read_write = dma_req ? dma_read_write : 1'b1;
    end else if (state_q == HANDOVER) begin
      mem_wdata      = '0;
      mem_read_write = 1'b1;
    end
  end

  assign rdata_load   = dma_ack & dma_read_write;
  assign dma_rvalid_d = rdata_load;
  assign dma_rvalid   = dma_rvalid_q;

  mem_bus_arbiter_reg #(
    .W(DATA_W)
  ) u_rdata_reg (
    .clk_in(clk_in),
    .reset (reset),
    .load_i(rdata_load),
    .d_i   (mem_rdata),
    .q_o   (dma_rdata)
  );

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  localparam int MAXB = 4;

  logic        clk_in = 1'b0;
  logic        reset;
  logic [15:0] cpu_address;
  logic [7:0]  cpu_data_out;
  logic        cpu_read_write;
  logic [7:0]  cpu_data_in;
  logic        cpu_ready;
  logic        dma_req;
  logic [15:0] dma_address;
  logic [7:0]  dma_wdata;
  logic        dma_read_write;
  logic        dma_gnt;
  logic        dma_ack;
  logic [7:0]  dma_rdata;
  logic        dma_rvalid;
  logic [15:0] mem_address;
  logic [7:0]  mem_wdata;
  logic        mem_read_write;
  logic [7:0]  mem_rdata;

  always #5 clk_in = ~clk_in;

  mem_bus_arbiter #(
    .MAX_BURST(MAXB),
    .ADDR_W   (16),
    .DATA_W   (8)
  ) dut (
    .clk_in        (clk_in),
    .reset         (reset),
    .cpu_address   (cpu_address),
    .cpu_data_out  (cpu_data_out),
    .cpu_read_write(cpu_read_write),
    .cpu_data_in   (cpu_data_in),
    .cpu_ready     (cpu_ready),
    .dma_req       (dma_req),
    .dma_address   (dma_address),
    .dma_wdata     (dma_wdata),
    .dma_read_write(dma_read_write),
    .dma_gnt       (dma_gnt),
    .dma_ack       (dma_ack),
    .dma_rdata     (dma_rdata),
    .dma_rvalid    (dma_rvalid),
    .mem_address   (mem_address),
    .mem_wdata     (mem_wdata),
    .mem_read_write(mem_read_write),
    .mem_rdata     (mem_rdata)
  );

  // Memory contents as a fixed function of address.
  function automatic logic [7:0] memf(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
  endfunction

  assign mem_rdata = memf(mem_address);

  typedef struct {
    logic        ready;
    logic        gnt;
    logic        ack;
    logic        rw;
    logic        rvalid;
    logic [15:0] addr;
    logic [7:0]  wd;
    logic [7:0]  rdata;
    logic [7:0]  cdin;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: who owns the bus, and how many DMA accesses remain in
  // the current grant.
  typedef enum {M_CPU, M_TURN, M_DMA, M_GUARD} mmode_t;
  mmode_t     m_mode   = M_CPU;
  int         m_budget = 0;
  logic       m_rvalid = 1'b0;
  logic [7:0] m_rdata  = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, expv);
    end
  endtask

  always @(negedge clk_in) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("cpu_ready",      32'(cpu_ready),      32'(e.ready));
      chk("dma_gnt",        32'(dma_gnt),        32'(e.gnt));
      chk("dma_ack",        32'(dma_ack),        32'(e.ack));
      chk("mem_address",    32'(mem_address),    32'(e.addr));
      chk("mem_read_write", 32'(mem_read_write), 32'(e.rw));
      chk("mem_wdata",      32'(mem_wdata),      32'(e.wd));
      chk("cpu_data_in",    32'(cpu_data_in),    32'(e.cdin));
      chk("dma_rvalid",     32'(dma_rvalid),     32'(e.rvalid));
      chk("dma_rdata",      32'(dma_rdata),      32'(e.rdata));
    end
  end

  // One bus cycle: drive inputs, predict this cycle's outputs, advance model.
  task automatic step(input logic rst, input logic [15:0] ca, input logic [7:0] cwd,
                      input logic crw, input logic req, input logic [15:0] da,
                      input logic [7:0] dwd, input logic drw);
    exp_t e;
    reset          = rst;
    cpu_address    = ca;
    cpu_data_out   = cwd;
    cpu_read_write = crw;
    dma_req        = req;
    dma_address    = da;
    dma_wdata      = dwd;
    dma_read_write = drw;

    e.rvalid = m_rvalid;
    e.rdata  = m_rdata;
    e.ready  = (m_mode == M_CPU) || (m_mode == M_GUARD);
    e.gnt    = (m_mode == M_DMA);
    e.ack    = (m_mode == M_DMA) && req;
    if (m_mode == M_DMA) begin
      e.addr = da;
      e.wd   = dwd;
      e.rw   = req ? drw : 1'b1;
    end else if (m_mode == M_TURN) begin
      e.addr = ca;
      e.wd   = 8'h00;
      e.rw   = 1'b1;
    end else begin
      e.addr = ca;
      e.wd   = cwd;
      e.rw   = crw;
    end
    e.cdin = memf(e.addr);
    exp_q.push_back(e);

    @(posedge clk_in);
    #1;

    if (rst) begin
      m_mode   = M_CPU;
      m_budget = 0;
      m_rvalid = 1'b0;
      m_rdata  = 8'h00;
    end else begin
      m_rvalid = e.ack && drw;
      if (e.ack && drw) m_rdata = memf(da);
      case (m_mode)
        M_CPU:   if (req && crw) m_mode = M_TURN;
        M_TURN:  begin m_mode = M_DMA; m_budget = MAXB; end
        M_DMA: begin
          if (!req) m_mode = M_CPU;
          else begin
            m_budget = m_budget - 1;
            if (m_budget == 0) m_mode = M_GUARD;
          end
        end
        default: m_mode = M_CPU;
      endcase
    end
  endtask

  initial begin
    // First reset edge from an unknown state; outputs are not yet defined.
    reset = 1'b1; cpu_address = 16'h1234; cpu_data_out = 8'h00; cpu_read_write = 1'b1;
    dma_req = 1'b1; dma_address = 16'h8000; dma_wdata = 8'h00; dma_read_write = 1'b1;
    @(posedge clk_in);
    #1;

    // Reset held with dma_req=1, then first cycle after reset.
    step(1, 16'h1234, 8'h00, 1, 1, 16'h8000, 8'h00, 1);
    step(0, 16'h1234, 8'h00, 1, 0, 16'h8000, 8'h00, 1);

    // CPU read, short DMA read burst, then release.
    step(0, 16'h1234, 8'h00, 1, 1, 16'h8000, 8'h00, 1);
    step(0, 16'h1234, 8'h00, 1, 1, 16'h8000, 8'h00, 1);
    step(0, 16'h1234, 8'h00, 1, 1, 16'h8000, 8'h00, 1);
    step(0, 16'h1234, 8'h00, 1, 1, 16'h8001, 8'h00, 1);
    step(0, 16'h1234, 8'h00, 1, 0, 16'h8002, 8'h00, 1);
    step(0, 16'h1234, 8'h00, 1, 0, 16'h8002, 8'h00, 1);

    // CPU writes are never interrupted; grant follows the first read.
    for (int i = 0; i < 4; i++)
      step(0, 16'h0300 + 16'(i), 8'h10 + 8'(i), 0, 1, 16'h9000, 8'h00, 1);
    step(0, 16'h0400, 8'h00, 1, 1, 16'h9000, 8'h00, 1);
    step(0, 16'h0400, 8'h00, 1, 1, 16'h9000, 8'h00, 1);
    step(0, 16'h0400, 8'h00, 1, 0, 16'h9000, 8'h00, 1);

    // Held request: capped bursts separated by a guaranteed CPU cycle.
    for (int i = 0; i < 16; i++)
      step(0, 16'h0500, 8'h00, 1, 1, 16'hA000 + 16'(i), 8'h00, 1);
    step(0, 16'h0500, 8'h00, 1, 0, 16'hA000, 8'h00, 1);
    step(0, 16'h0500, 8'h00, 1, 0, 16'hA000, 8'h00, 1);

    // DMA write; turnaround cycle must not write.
    step(0, 16'h0600, 8'hEE, 1, 1, 16'h0200, 8'h5A, 0);
    step(0, 16'h0600, 8'hEE, 1, 1, 16'h0200, 8'h5A, 0);
    step(0, 16'h0600, 8'hEE, 1, 1, 16'h0200, 8'h5A, 0);
    step(0, 16'h0600, 8'hEE, 1, 0, 16'h0200, 8'h5A, 0);
    step(0, 16'h0600, 8'hEE, 1, 0, 16'h0200, 8'h5A, 0);

    // Reset mid-burst after two acks, then a full burst must still follow.
    step(0, 16'h0700, 8'h00, 1, 1, 16'hB000, 8'h00, 1);
    step(0, 16'h0700, 8'h00, 1, 1, 16'hB000, 8'h00, 1);
    step(0, 16'h0700, 8'h00, 1, 1, 16'hB000, 8'h00, 1);
    step(0, 16'h0700, 8'h00, 1, 1, 16'hB001, 8'h00, 1);
    step(1, 16'h0700, 8'h00, 1, 1, 16'hB002, 8'h00, 1);
    for (int i = 0; i < 9; i++)
      step(0, 16'h0700, 8'h00, 1, 1, 16'hC000 + 16'(i), 8'h00, 1);

    // Request dropped during turnaround.
    step(0, 16'h0800, 8'h00, 1, 1, 16'hD000, 8'h00, 1);
    step(0, 16'h0800, 8'h00, 1, 0, 16'hD000, 8'h00, 1);
    step(0, 16'h0800, 8'h00, 1, 0, 16'hD000, 8'h00, 1);
    step(0, 16'h0800, 8'h00, 1, 0, 16'hD000, 8'h00, 1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 63) == 0),
           16'($urandom), 8'($urandom), ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 9) < 6),
           16'($urandom), 8'($urandom), 1'($urandom));
    end
    reset = 1'b0;
    dma_req = 1'b0;

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk_in);
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single external memory port between cpu6502 and one DMA-style requester (e.g. video/UART buffer filler).
- The CPU is the default owner. DMA gets the bus only when the CPU is on a read cycle, so CPU writes are never stalled.
- The CPU is stalled through a cpu_ready clock-enable.
- DMA bursts are capped, and each capped burst is followed by a guaranteed CPU cycle to bound CPU starvation.

Parameters:
- MAX_BURST, 4, maximum consecutive DMA accesses per grant; legal range 1..255.
- ADDR_W, 16, address width.
- DATA_W, 8, data width.

Ports:
- clk_in  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- cpu_address  in  ADDR_W  CPU address_out
- cpu_data_out  in  DATA_W  CPU write data
- cpu_read_write  in  1  1=read, 0=write (CPU READ_write)
- cpu_data_in  out  DATA_W  read data to CPU
- cpu_ready  out  1  CPU clock enable; 0 = CPU must hold state
- dma_req  in  1  DMA requests an access this cycle
- dma_address  in  ADDR_W  DMA address
- dma_wdata  in  DATA_W  DMA write data
- dma_read_write  in  1  1=read, 0=write
- dma_gnt  out  1  DMA owns the bus this cycle
- dma_ack  out  1  DMA access performed this cycle
- dma_rdata  out  DATA_W  registered read data
- dma_rvalid  out  1  dma_rdata holds data from the access acked last cycle
- mem_address  out  ADDR_W  to memory
- mem_wdata  out  DATA_W  to memory
- mem_read_write  out  1  to memory, 1=read
- mem_rdata  in  DATA_W  memory read data; combinational, valid in the same cycle

Behaviour:
- Reset values: state=CPU_OWN, burst_cnt=0, dma_rdata=0, dma_rvalid=0. This gives cpu_ready=1, dma_gnt=0, dma_ack=0, and the memory port follows the CPU.
- cpu_data_in = mem_rdata always (combinational).
- State machine (arb_state_t) — state and transitions:
  - CPU_OWN
    - Memory port driven by the cpu_* inputs; cpu_ready=1.
    - If dma_req=1 and cpu_read_write=1, go to HANDOVER. The CPU's read in this cycle still completes.
    - If dma_req=1 and cpu_read_write=0, stay. Writes are never interrupted.
  - HANDOVER
    - Turnaround cycle: mem_address=cpu_address, mem_read_write=1, mem_wdata=0.
    - cpu_ready=0, dma_gnt=0.
    - Always go to DMA_OWN; burst_cnt cleared to 0.
  - DMA_OWN
    - Memory port driven by the dma_* inputs; dma_gnt=1; cpu_ready=0.
    - dma_ack = dma_req.
    - On ack: burst_cnt increments.
    - If dma_req=0 this cycle, go to CPU_OWN with no ack and no memory write (mem_read_write forced to 1).
    - If the ack makes burst_cnt equal MAX_BURST, go to COOLDOWN.
  - COOLDOWN
    - Identical outputs to CPU_OWN, but dma_req is ignored.
    - Always go to CPU_OWN after exactly one cycle. From there DMA may be re-granted if the CPU is reading.
- dma_rdata/dma_rvalid: on a cycle with dma_ack=1 and dma_read_write=1, capture mem_rdata and set dma_rvalid=1 next cycle. Otherwise dma_rvalid=0 next cycle; dma_rdata holds.
- burst_cnt width is $clog2(MAX_BURST+1) and never wraps. MAX_BURST=1 gives a single access followed by COOLDOWN.
- dma_req dropping in HANDOVER: DMA_OWN is still entered, then returns to CPU_OWN with no ack. The cost is two stall cycles; this is acceptable and required.
- Reset mid-burst: next edge returns to CPU_OWN with dma_gnt=0. The in-flight DMA access in that reset cycle is still driven to memory. dma_rvalid clears.
- No combinational path from dma_req to cpu_ready. cpu_ready depends on state only.

Decomposition:
- Shared package arbiter_pkg containing:
  - arb_state_t: CPU_OWN, HANDOVER, DMA_OWN, COOLDOWN, ArbStateEndMarker.
  - bus_owner_t: BusOwnerCpu, BusOwnerDma, used to select the memory mux.
- Reuse the existing register module for the dma_rdata latch; its load is dma_ack & dma_read_write.
- No other sub-module.

Test Plan:
- Reset with dma_req=1 held -> during reset and the first cycle after: cpu_ready=1, dma_gnt=0, mem_address=cpu_address.
- CPU read at 0x1234, dma_req=1 with dma reads at 0x8000..0x8001, then dma_req=0:
  - cycle 0: CPU read completes.
  - cycle 1: HANDOVER, cpu_ready=0.
  - cycles 2–3: acks with mem_address 0x8000/0x8001; dma_rvalid=1 on cycles 3–4 with matching memory data.
  - cycle 4: no ack (dma_req=0).
  - cycle 5: cpu_ready=1.
- CPU write (cpu_read_write=0) with dma_req=1 -> no HANDOVER while writes continue; grant occurs only after the first CPU read cycle.
- MAX_BURST=4, dma_req held high -> exactly 4 acks, then one COOLDOWN cycle with cpu_ready=1, then HANDOVER again if the CPU is reading. Pattern repeats with 4 acks per 7 cycles.
- DMA write 0x5A to 0x0200 in DMA_OWN -> mem_read_write=0, mem_wdata=0x5A, mem_address=0x0200. No memory write occurs in HANDOVER.
- reset asserted mid-burst after 2 acks -> next cycle: dma_gnt=0, dma_rvalid=0, cpu_ready=1, burst_cnt=0.
